// File: rtl/adc_spi_responder.sv
// SPI responder that streams a per-channel sample to an ADC SPI master and captures its control word.
// Optional build macro: ADC_RESP_RAMP_EN (reported table entry auto-increments at frame completion).
module adc_spi_responder (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        adc_sclk,
  input  logic        adc_cs_n,
  input  logic        adc_din,
  output logic        adc_dout,
  input  logic        ch_wr_en,
  input  logic [2:0]  ch_wr_addr,
  input  logic [11:0] ch_wr_data,
  output logic [15:0] ctrl_word,
  output logic        ctrl_valid,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  logic        cs_meta_r, cs_sync_r, cs_prev_r;
  logic        sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic        din_meta_r, din_sync_r;
  logic [2:0]  prime_r;
  state_t      state_r, state_n;
  logic [15:0] tx_shift_r, tx_n;
  logic [15:0] rx_shift_r, rx_n;
  logic [4:0]  bit_cnt_r, cnt_n;
  logic [2:0]  cur_addr_r, cur_n;
  logic [2:0]  frame_addr_r, faddr_n;
  logic [15:0] word_n, rx_word_s;
  logic        valid_n, err_n, dout_n;
  logic        settled_s, cs_fall_s, cs_rise_s, sclk_fall_s, ramp_s;
  logic [11:0] chan_tab_r [8];

  // Input synchronizers plus previous-sample flops for edge detection.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cs_meta_r   <= 1'b1;
      cs_sync_r   <= 1'b1;
      cs_prev_r   <= 1'b1;
      sclk_meta_r <= 1'b1;
      sclk_sync_r <= 1'b1;
      sclk_prev_r <= 1'b1;
      din_meta_r  <= 1'b0;
      din_sync_r  <= 1'b0;
      prime_r     <= 3'b000;
    end else begin
      cs_meta_r   <= adc_cs_n;
      cs_sync_r   <= cs_meta_r;
      cs_prev_r   <= cs_sync_r;
      sclk_meta_r <= adc_sclk;
      sclk_sync_r <= sclk_meta_r;
      sclk_prev_r <= sclk_sync_r;
      din_meta_r  <= adc_din;
      din_sync_r  <= din_meta_r;
      prime_r     <= {prime_r[1:0], 1'b1};
    end
  end

  // The synchronizers hold reset values, not pin samples, until three clocks after reset;
  // prime_r keeps those fake levels from being read as edges or as a released cs_n.
  assign settled_s   = prime_r[2];
  assign cs_fall_s   = cs_prev_r & ~cs_sync_r;
  assign cs_rise_s   = ~cs_prev_r & cs_sync_r;
  assign sclk_fall_s = sclk_prev_r & ~sclk_sync_r;
  assign rx_word_s   = {rx_shift_r[14:0], din_sync_r};

  // Next-state and datapath decisions for the frame FSM.
  always_comb begin
    state_n = state_r;
    tx_n    = tx_shift_r;
    rx_n    = rx_shift_r;
    cnt_n   = bit_cnt_r;
    cur_n   = cur_addr_r;
    faddr_n = frame_addr_r;
    word_n  = ctrl_word;
    valid_n = 1'b0;
    err_n   = 1'b0;
    case (state_r)
      IDLE: begin
        if (settled_s && cs_fall_s) begin
          state_n = SHIFT;
          tx_n    = {1'b0, cur_addr_r, chan_tab_r[cur_addr_r]};
          rx_n    = 16'h0000;
          cnt_n   = 5'd0;
          faddr_n = cur_addr_r;
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        if (cs_rise_s) begin
          state_n = IDLE;
          err_n   = 1'b1;
          rx_n    = 16'h0000;
          tx_n    = 16'h0000;
          cnt_n   = 5'd0;
        end else if (sclk_fall_s) begin
          rx_n  = rx_word_s;
          tx_n  = {tx_shift_r[14:0], 1'b0};
          cnt_n = bit_cnt_r + 5'd1;
          if (bit_cnt_r == 5'd15) begin
            state_n = DONE;
            word_n  = rx_word_s;
            valid_n = 1'b1;
            if (rx_word_s[15]) begin
              cur_n = rx_word_s[12:10];
            end else begin
              cur_n = cur_addr_r;
            end
          end else begin
            state_n = SHIFT;
          end
        end else begin
          state_n = SHIFT;
        end
      end
      DONE: begin
        // Level rather than edge: a cs_n already high when reset releases still reaches IDLE.
        if (settled_s && cs_sync_r) begin
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: begin
        state_n = DONE;
      end
    endcase
    dout_n = ((state_n == SHIFT) && !cs_sync_r) ? tx_n[15] : 1'b0;
  end

`ifdef ADC_RESP_RAMP_EN
  assign ramp_s = valid_n;
`else
  assign ramp_s = 1'b0;
`endif

  // FSM, shift registers and registered outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_r      <= DONE;
      tx_shift_r   <= 16'h0000;
      rx_shift_r   <= 16'h0000;
      bit_cnt_r    <= 5'd0;
      cur_addr_r   <= 3'd0;
      frame_addr_r <= 3'd0;
      ctrl_word    <= 16'h0000;
      ctrl_valid   <= 1'b0;
      frame_err    <= 1'b0;
      busy         <= 1'b0;
      adc_dout     <= 1'b0;
    end else begin
      state_r      <= state_n;
      tx_shift_r   <= tx_n;
      rx_shift_r   <= rx_n;
      bit_cnt_r    <= cnt_n;
      cur_addr_r   <= cur_n;
      frame_addr_r <= faddr_n;
      ctrl_word    <= word_n;
      ctrl_valid   <= valid_n;
      frame_err    <= err_n;
      busy         <= (state_n == SHIFT);
      adc_dout     <= dout_n;
    end
  end

  // Channel table: host writes win over the ramp increment on the same entry.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 8; i++) begin
        chan_tab_r[i] <= 12'h000;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (ch_wr_en && (ch_wr_addr == 3'(i))) begin
          chan_tab_r[i] <= ch_wr_data;
        end else if (ramp_s && (frame_addr_r == 3'(i))) begin
          chan_tab_r[i] <= chan_tab_r[i] + 12'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed scoreboard bench for adc_spi_responder; honours ADC_RESP_RAMP_EN in its reference model.
module tb_adc_spi_responder;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        adc_sclk = 1'b1;
  logic        adc_cs_n = 1'b1;
  logic        adc_din = 1'b0;
  logic        adc_dout;
  logic        ch_wr_en = 1'b0;
  logic [2:0]  ch_wr_addr = 3'd0;
  logic [11:0] ch_wr_data = 12'h000;
  logic [15:0] ctrl_word;
  logic        ctrl_valid;
  logic        frame_err;
  logic        busy;

  adc_spi_responder dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .adc_sclk     (adc_sclk),
    .adc_cs_n     (adc_cs_n),
    .adc_din      (adc_din),
    .adc_dout     (adc_dout),
    .ch_wr_en     (ch_wr_en),
    .ch_wr_addr   (ch_wr_addr),
    .ch_wr_data   (ch_wr_data),
    .ctrl_word    (ctrl_word),
    .ctrl_valid   (ctrl_valid),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk_clk = ~clk_clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  // Reference model state and scoreboard queues.
  logic [11:0] tbl [8];
  logic [2:0]  cur;
  logic [15:0] exp_dout_q [$];
  logic [15:0] exp_ctrl_q [$];

  // Pulse counters for ctrl_valid and frame_err.
  always @(negedge clk_clk) begin
    if (ctrl_valid) valid_cnt++;
    if (frame_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic host_wr(input logic [2:0] a, input logic [11:0] d);
    @(negedge clk_clk);
    ch_wr_en   = 1'b1;
    ch_wr_addr = a;
    ch_wr_data = d;
    @(negedge clk_clk);
    ch_wr_en   = 1'b0;
    tbl[a]     = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) tbl[i] = 12'h000;
    cur = 3'd0;
  endtask

  // One SPI frame: dout sampled before each falling sclk edge, din held across it.
  task automatic frame(input logic [15:0] dw, input int n, input bit open_cs, input bit close_cs,
                       input int wr_at, input logic [2:0] wa, input logic [11:0] wd,
                       output logic [31:0] got);
    logic [2:0] rep;
    got = 32'h0;
    rep = cur;
    if (open_cs) begin
      exp_dout_q.push_back({1'b0, cur, tbl[cur]});
      adc_cs_n = 1'b0;
      repeat (8) @(negedge clk_clk);
      check("busy_in_frame", {31'h0, busy}, 32'h1);
    end
    for (int i = 0; i < n; i++) begin
      if (i == wr_at) host_wr(wa, wd);
      adc_din = (i < 16) ? dw[15 - i] : 1'b1;
      repeat (4) @(negedge clk_clk);
      got = {got[30:0], adc_dout};
      adc_sclk = 1'b0;
      repeat (8) @(negedge clk_clk);
      adc_sclk = 1'b1;
      repeat (8) @(negedge clk_clk);
    end
    if (open_cs && n >= 16) begin
      exp_ctrl_q.push_back(dw);
      if (dw[15]) cur = dw[12:10];
`ifdef ADC_RESP_RAMP_EN
      tbl[rep] = tbl[rep] + 12'd1;
`endif
    end
    if (close_cs) begin
      adc_cs_n = 1'b1;
      adc_din  = 1'b0;
      repeat (10) @(negedge clk_clk);
    end
  endtask

  initial begin
    logic [31:0] got;
    logic [15:0] e;
    int v0;
    int e0;

    model_reset();
    repeat (5) @(negedge clk_clk);
    check("rst_dout", {31'h0, adc_dout}, 32'h0);
    check("rst_ctrl_word", {16'h0, ctrl_word}, 32'h0);
    check("rst_ctrl_valid", {31'h0, ctrl_valid}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    reset_reset_n = 1'b1;
    repeat (10) @(negedge clk_clk);

    host_wr(3'd0, 12'hABC);
    host_wr(3'd5, 12'h123);
    host_wr(3'd2, 12'hFFF);

    // Scenario 1: plain read of channel 0.
    v0 = valid_cnt;
    frame(16'h0000, 16, 1'b1, 1'b1, -1, 3'd0, 12'h000, got);
    check("s1_dout", got, {16'h0, exp_dout_q.pop_front()});
    check("s1_dout_const", got, 32'h0ABC);
    check("s1_valid_pulses", v0 + 1, valid_cnt);
    check("s1_ctrl_word", {16'h0, ctrl_word}, {16'h0, exp_ctrl_q.pop_front()});
    check("s1_busy_after", {31'h0, busy}, 32'h0);

    // Scenario 2: WRITE selects channel 5 for the following frame.
    frame(16'h9400, 16, 1'b1, 1'b1, -1, 3'd0, 12'h000, got);
    check("s2a_dout", got, {16'h0, exp_dout_q.pop_front()});
    check("s2a_ctrl_word", {16'h0, ctrl_word}, {16'h0, exp_ctrl_q.pop_front()});
    frame(16'h0000, 16, 1'b1, 1'b1, -1, 3'd0, 12'h000, got);
    check("s2b_dout", got, {16'h0, exp_dout_q.pop_front()});
    void'(exp_ctrl_q.pop_front());

    // Scenario 3: abort after 9 edges, then a normal frame.
    v0 = valid_cnt;
    e0 = err_cnt;
    frame(16'h9C00, 9, 1'b1, 1'b1, -1, 3'd0, 12'h000, got);
    e = exp_dout_q.pop_front();
    check("s3_partial_dout", got, {23'h0, e[15:7]});
    check("s3_frame_err_pulses", e0 + 1, err_cnt);
    check("s3_no_valid", v0, valid_cnt);
    check("s3_ctrl_word_kept", {16'h0, ctrl_word}, 32'h0);
    frame(16'h0000, 16, 1'b1, 1'b1, -1, 3'd0, 12'h000, got);
    check("s3_next_dout", got, {16'h0, exp_dout_q.pop_front()});
    void'(exp_ctrl_q.pop_front());

    // Scenario 4: 20 edges, extra din bits are ones and must be ignored.
    v0 = valid_cnt;
    frame(16'h8800, 20, 1'b1, 1'b1, -1, 3'd0, 12'h000, got);
    check("s4_dout_word", {16'h0, got[19:4]}, {16'h0, exp_dout_q.pop_front()});
    check("s4_tail_zero", {28'h0, got[3:0]}, 32'h0);
    check("s4_ctrl_word", {16'h0, ctrl_word}, {16'h0, exp_ctrl_q.pop_front()});
    check("s4_one_valid", v0 + 1, valid_cnt);

    // Scenario 6 sequence on channel 2 (0xFFF): wraps only with the ramp build.
    frame(16'h0000, 16, 1'b1, 1'b1, -1, 3'd0, 12'h000, got);
    check("s6a_dout", got, {16'h0, exp_dout_q.pop_front()});
    check("s6a_dout_const", got, 32'h2FFF);
    void'(exp_ctrl_q.pop_front());
    frame(16'h0000, 16, 1'b1, 1'b1, -1, 3'd0, 12'h000, got);
    check("s6b_dout", got, {16'h0, exp_dout_q.pop_front()});
`ifdef ADC_RESP_RAMP_EN
    check("s6b_dout_const", got, 32'h2000);
`else
    check("s6b_dout_const", got, 32'h2FFF);
`endif
    void'(exp_ctrl_q.pop_front());

    // Scenario 5: reset mid-frame with cs_n held low.
    frame(16'h0000, 4, 1'b1, 1'b0, -1, 3'd0, 12'h000, got);
    e = exp_dout_q.pop_front();
    check("s5_partial_dout", got, {28'h0, e[15:12]});
    reset_reset_n = 1'b0;
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    model_reset();
    v0 = valid_cnt;
    frame(16'h0000, 14, 1'b0, 1'b0, -1, 3'd0, 12'h000, got);
    check("s5_no_valid_in_frame", v0, valid_cnt);
    check("s5_busy_low", {31'h0, busy}, 32'h0);
    check("s5_dout_low", got, 32'h0);
    adc_cs_n = 1'b1;
    repeat (10) @(negedge clk_clk);
    check("s5_no_valid_after_cs_high", v0, valid_cnt);

    // Host write to the entry in flight must not change the frame.
    host_wr(3'd0, 12'h456);
    frame(16'h0000, 16, 1'b1, 1'b1, 5, 3'd0, 12'h999, got);
    check("s5_frame_dout", got, {16'h0, exp_dout_q.pop_front()});
    check("s5_frame_dout_const", got, 32'h0456);
    check("s5_valid_after_reframe", v0 + 1, valid_cnt);
    void'(exp_ctrl_q.pop_front());
    frame(16'h0000, 16, 1'b1, 1'b1, -1, 3'd0, 12'h000, got);
    check("s5_written_value", got, {16'h0, exp_dout_q.pop_front()});
    void'(exp_ctrl_q.pop_front());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/adc_spi_responder.md
ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

Interface
REQ-001 SHALL have port clk_clk, input, 1 bit: the single system clock; all logic is synchronous to its rising edge.
REQ-002 SHALL have port reset_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port adc_sclk, input, 1 bit: serial clock from the ADC SPI master; idles high.
REQ-004 SHALL have port adc_cs_n, input, 1 bit: active-low frame select from the master.
REQ-005 SHALL have port adc_din, input, 1 bit: master-to-responder control bits, MSB first.
REQ-006 SHALL have port adc_dout, output, 1 bit: responder-to-master conversion bits, MSB first.
REQ-007 SHALL have port ch_wr_en, input, 1 bit: host write strobe for the channel sample table.
REQ-008 SHALL have port ch_wr_addr, input, 3 bits: channel index to write.
REQ-009 SHALL have port ch_wr_data, input, 12 bits: sample value to write.
REQ-010 SHALL have port ctrl_word, output, 16 bits: last complete control word received.
REQ-011 SHALL have port ctrl_valid, output, 1 bit: one-cycle pulse when ctrl_word updates.
REQ-012 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame is aborted.
REQ-013 SHALL have port busy, output, 1 bit: high while in SHIFT.

Function
REQ-014 SHALL pass adc_sclk, adc_cs_n and adc_din through 2-flop synchronizers; edge detection uses the synchronized signals; clk_clk SHALL be at least 8x the sclk rate.
REQ-015 SHALL hold an 8 x 12-bit channel table; ch_wr_en writes ch_wr_data into entry ch_wr_addr on the next clock edge.
REQ-016 SHALL hold a 3-bit cur_addr register that selects the channel reported in the next frame.
REQ-017 SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-018 In IDLE, a synchronized cs_n falling edge SHALL load tx_shift with {1'b0, cur_addr, table[cur_addr]}, clear bit_cnt and enter SHIFT; adc_dout then presents tx_shift[15].
REQ-019 In SHIFT, each synchronized sclk falling edge SHALL shift adc_din into rx_shift (LSB in), shift tx_shift left with 0 fill, and increment bit_cnt; adc_dout updates within 3 clk_clk cycles of the pin edge.
REQ-020 On the 16th falling edge, the block SHALL: load ctrl_word from rx_shift; pulse ctrl_valid; if bit 15 (WRITE) is 1, load cur_addr from bits 12:10, otherwise leave cur_addr unchanged; then enter DONE.
REQ-021 In DONE, additional sclk edges SHALL be ignored and adc_dout SHALL be 0; a cs_n rising edge SHALL return the FSM to IDLE.
REQ-022 A cs_n rising edge in SHIFT with bit_cnt<16 SHALL pulse frame_err, discard rx_shift, leave ctrl_word and cur_addr unchanged, and return to IDLE.
REQ-023 Whenever cs_n (synchronized) is high, adc_dout SHALL be 0; the output is never tri-stated.
REQ-024 A host write to the entry being shifted SHALL NOT alter the frame in flight, because the value is latched at frame start.

Reset
REQ-025 Reset SHALL set: adc_dout=0, ctrl_word=0, ctrl_valid=0, frame_err=0, busy=0, cur_addr=0, all table entries=0, shift registers and bit_cnt=0, synchronizer flops=1 (cs_n, sclk) and 0 (din).
REQ-026 On reset release the FSM SHALL be in DONE, so a frame already in progress is ignored until cs_n goes high.

Configuration
REQ-027 With macro ADC_RESP_RAMP_EN defined, at the 16th falling edge the reported table entry SHALL increment by 1 modulo 4096 (0xFFF wraps to 0x000); a host write to the same entry in the same cycle SHALL take priority. Without the macro, table entries change only by host write.

Verification
REQ-028 Scenario 1: after reset, with table[0]=0xABC, run one 16-bit frame with din=0x0000. Dout SHALL be 0x0ABC, ctrl_word=0x0000 with one ctrl_valid pulse, and cur_addr SHALL stay 0.
REQ-029 Scenario 2: with table[5]=0x123, send din=0x9400 (WRITE=1, ADD=5), then a second frame. The second frame's dout SHALL be 0x5123.
REQ-030 Scenario 3: raise cs_n after 9 sclk edges. frame_err SHALL pulse once, there SHALL be no ctrl_valid pulse, and the next full frame SHALL work normally with the prior cur_addr.
REQ-031 Scenario 4: apply 20 sclk edges in one frame. Bits 17-20 SHALL read 0 on dout, and ctrl_word SHALL hold the first 16 bits.
REQ-032 Scenario 5: assert reset mid-frame while cs_n stays low. No ctrl_valid pulse SHALL occur until cs_n goes high and then low again.
REQ-033 Scenario 6 (ADC_RESP_RAMP_EN defined): with table[2]=0xFFF and cur_addr=2, run two frames. Dout SHALL be 0x2FFF, then 0x2000.
